tdc_capture: RTL and testbench

TDC_CAPTURE -- requirements
Module: tdc_capture

---
 rtl/tdc_capture.sv | 205 ++++++++++++++++++++
 tb/tb_tdc_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_capture.sv
// Two-flop sampled delay-line TDC with coarse cycle counter and valid/ready result.
// Optional TDC_BUBBLE_FIX_EN: majority-of-3 bubble filter before the tap count.
module delay_line #(
    parameter int    N       = 32,
    parameter string DL_TYPE = "rca"
) (
    input  logic         din,
    output logic [N-1:0] taps
);

    generate
        if (DL_TYPE == "rca") begin : g_rca
            for (genvar i = 0; i < N; i++) begin : g_stage
                logic c;
                if (i == 0) begin : g_first
                    assign c = din;
                end else begin : g_next
                    assign c = g_stage[i-1].c & din;
                end
                assign taps[i] = c;
            end
        end else begin : g_fanout
            assign taps = {N{din}};
        end
    endgenerate

endmodule

module tdc_capture #(
    parameter int    N        = 32,
    parameter string DL_TYPE  = "rca",
    parameter int    COARSE_W = 4,
    localparam int   FINE_W   = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hit,
    input  logic                start,
    input  logic                ready,
    output logic                busy,
    output logic                valid,
    output logic [FINE_W-1:0]   fine,
    output logic [COARSE_W-1:0] coarse,
    output logic                overflow,
    output logic                timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ENCODE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]        taps;
    logic [N-1:0]        s1;
    logic [N-1:0]        s2;
    logic [N-1:0]        code_lat;
    logic [COARSE_W-1:0] cnt;
    logic                code_nz;
    logic                cnt_max;
    logic [FINE_W-1:0]   fine_d;

    delay_line #(
        .N       (N),
        .DL_TYPE (DL_TYPE)
    ) u_dl (
        .din  (hit),
        .taps (taps)
    );

    function automatic logic [FINE_W-1:0] popcnt(input logic [N-1:0] v);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) begin
            n = n + FINE_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [FINE_W-1:0] msb_pos(input logic [N-1:0] v);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                n = FINE_W'(i + 1);
            end
        end
        return n;
    endfunction

    // Below-line edge reads as set, above-line edge as clear.
    function automatic logic [N-1:0] maj3(input logic [N-1:0] v);
        logic [N+1:0] ext;
        logic [N-1:0] r;
        ext = {1'b0, v, 1'b1};
        for (int i = 0; i < N; i++) begin
            r[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2])
                 | (ext[i+1] & ext[i+2]);
        end
        return r;
    endfunction

`ifdef TDC_BUBBLE_FIX_EN
    assign fine_d = popcnt(maj3(code_lat));
`else
    assign fine_d = msb_pos(code_lat);
`endif

    assign code_nz = |s2;
    assign cnt_max = &cnt;
    assign busy    = (state_q != IDLE);
    assign valid   = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= taps;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !code_nz) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (code_nz) begin
                    state_d = ENCODE;
                end else if (cnt_max) begin
                    state_d = DONE;
                end
            end
            ENCODE: state_d = DONE;
            DONE: begin
                if (ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            code_lat <= '0;
            fine     <= '0;
            coarse   <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt <= '0;
                end
                ARMED: begin
                    if (code_nz) begin
                        code_lat <= s2;
                        coarse   <= cnt;
                    end else if (cnt_max) begin
                        coarse  <= cnt;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ENCODE: begin
                    fine     <= fine_d;
                    overflow <= (fine_d == FINE_W'(N));
                end
                DONE: begin
                    if (ready) begin
                        cnt      <= '0;
                        code_lat <= '0;
                        fine     <= '0;
                        coarse   <= '0;
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_capture.sv
// Directed bench for tdc_capture: tap code forced onto the delay-line outputs.
// Vector table plus hand sequences for reset, timeout and backpressure.
module tb_tdc_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hit;
    logic       start;
    logic       ready;
    logic       busy;
    logic       valid;
    logic [5:0] fine;
    logic [3:0] coarse;
    logic       overflow;
    logic       timeout;

    logic [31:0] force_val;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_capture #(
        .N        (32),
        .DL_TYPE  ("rca"),
        .COARSE_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit      (hit),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .valid    (valid),
        .fine     (fine),
        .coarse   (coarse),
        .overflow (overflow),
        .timeout  (timeout)
    );

    typedef struct {
        logic [31:0] tap;
        int          dly;
        int          exp_fine;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_fine"}, 32'(fine), 32'd0);
        chk({tag, "_coarse"}, 32'(coarse), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!valid && n < budget) begin
            step();
            n++;
        end
        if (!valid) chk("valid_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic quiesce();
        force_val = '0;
        repeat (3) step();
    endtask

    int n;

    initial begin
        force dut.taps = force_val;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        force_val = '0;
        hit   = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{32'h0000_00FF, 0, 8, 1'b0};
        vecs[1] = '{32'h0000_0001, 0, 1, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 2, 32, 1'b1};
        vecs[3] = '{32'h0000_7FFF, 5, 15, 1'b0};
        vecs[4] = '{32'h0000_000E, 0, 4, 1'b0};
`ifdef TDC_BUBBLE_FIX_EN
        vecs[5] = '{32'h0000_010F, 1, 4, 1'b0};
        vecs[6] = '{32'h0000_0005, 3, 2, 1'b0};
        vecs[7] = '{32'h8000_0000, 1, 0, 1'b0};
`else
        vecs[5] = '{32'h0000_010F, 1, 9, 1'b0};
        vecs[6] = '{32'h0000_0005, 3, 3, 1'b0};
        vecs[7] = '{32'h8000_0000, 1, 32, 1'b1};
`endif

        repeat (3) step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            arm();
            chk($sformatf("v%0d_busy_armed", i), 32'(busy), 32'd1);
            repeat (vecs[i].dly) step();
            force_val = vecs[i].tap;
            wait_valid(30, n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'd4);
            chk($sformatf("v%0d_fine", i), 32'(fine),
                32'(vecs[i].exp_fine));
            chk($sformatf("v%0d_overflow", i), 32'(overflow),
                32'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_coarse", i), 32'(coarse),
                32'(2 + vecs[i].dly));
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
            force_val = '0;
            ready = 1'b1;
            step();
            ready = 1'b0;
            chk_idle($sformatf("v%0d_after_hs", i));
            quiesce();
        end

        arm();
        force_val = 32'h0000_00FF;
        wait_valid(30, n);
        force_val = '0;
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            step();
            chk($sformatf("bp%0d_valid", c), 32'(valid), 32'd1);
            chk($sformatf("bp%0d_fine", c), 32'(fine), 32'd8);
            chk($sformatf("bp%0d_coarse", c), 32'(coarse), 32'd2);
        end
        start = 1'b1;
        ready = 1'b1;
        step();
        start = 1'b0;
        ready = 1'b0;
        chk_idle("bp_release");
        step();
        chk("bp_no_rearm", 32'(busy), 32'd0);

        ready = 1'b1;
        arm();
        force_val = 32'h0000_0003;
        wait_valid(30, n);
        chk("early_ready_valid", 32'(valid), 32'd1);
        step();
        chk("early_ready_drop", 32'(valid), 32'd0);
        ready = 1'b0;
        quiesce();

        arm();
        wait_valid(40, n);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_coarse", 32'(coarse), 32'hF);
        chk("to_fine", 32'(fine), 32'd0);
        chk("to_overflow", 32'(overflow), 32'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk_idle("to_after_hs");

        arm();
        repeat (3) step();
        rst_n = 1'b0;
        repeat (3) step();
        chk_idle("rst_armed");
        rst_n = 1'b1;
        arm();
        chk("rst_first_start", 32'(busy), 32'd1);
        force_val = 32'hFFFF_FFFF;
        wait_valid(30, n);
        chk("rst_done_ovf", 32'(overflow), 32'd1);
        force_val = '0;
        rst_n = 1'b0;
        repeat (3) step();
        chk_idle("rst_done");
        rst_n = 1'b1;
        step();

        force_val = 32'h0000_00FF;
        repeat (3) step();
        start = 1'b1;
        step();
        chk("busy_code_nz_a", 32'(busy), 32'd0);
        step();
        chk("busy_code_nz_b", 32'(busy), 32'd0);
        start = 1'b0;
        quiesce();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
